usb_pkt_echo: RTL and testbench

//   Packet-level echo engine on the user side of the ftdi_245fifo bridge. Consumes the 32-bit
//   RX stream (bridge otvalid/otready/otdata), validates a header word, forwards the payload,
//   and produces a framed reply on the TX stream (bridge itvalid/itready/itdata): reply header,

---
 rtl/usb_pkt_echo_if.sv | 22 ++
 rtl/usb_pkt_echo.sv | 141 ++++++++++++++
 tb/tb_usb_pkt_echo.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkt_echo_if.sv
// Word-stream bundle between the ftdi_245fifo bridge user side and the echo engine:
// "it*" carries words into the engine, "ot*" carries reply words out of it.
interface usb_pkt_echo_if;
  logic        itvalid;
  logic        itready;
  logic [31:0] itdata;
  logic        otvalid;
  logic        otready;
  logic [31:0] otdata;

  // Echo engine side: sinks the input stream, sources the reply stream.
  modport master (
    input  itvalid, itdata, otready,
    output itready, otvalid, otdata
  );

  // Bridge / environment side.
  modport slave (
    output itvalid, itdata, otready,
    input  itready, otvalid, otdata
  );
endinterface

// File: rtl/usb_pkt_echo.sv
// Packet echo engine: header check, payload echo, additive-checksum trailer. One-cycle latency
// through a registered reply slot; input stalls while that slot is held or while the trailer is emitted.
module usb_pkt_echo #(
  parameter logic [15:0] MAGIC_IN  = 16'hA55A,
  parameter logic [15:0] MAGIC_OUT = 16'h5AA5,
  parameter int unsigned MAX_LEN   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  usb_pkt_echo_if.master        bus,
  output logic                  busy,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           err_cnt
);

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_TRL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        otvalid_q, otvalid_d;
  logic [31:0] otdata_q, otdata_d;
  logic [31:0] sum_q, sum_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        out_free;
  logic        itready;
  logic        accept;
  logic [15:0] hdr_magic;
  logic [15:0] hdr_len;
  logic        hdr_legal;

  assign out_free  = ~otvalid_q | bus.otready;
  assign hdr_magic = bus.itdata[31:16];
  assign hdr_len   = bus.itdata[15:0];
  assign hdr_legal = (hdr_magic == MAGIC_IN) && (32'(hdr_len) <= MAX_LEN);
  assign accept    = bus.itvalid & itready;

  // Input is only offered when the reply slot can take the resulting word, so
  // every accepted header/payload word maps to exactly one load next cycle.
  always_comb begin
    itready = 1'b0;
    if (rst_n && (state_q != S_TRL)) begin
      itready = out_free;
    end
  end

  always_comb begin
    state_d   = state_q;
    otvalid_d = otvalid_q;
    otdata_d  = otdata_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;

    if (out_free) begin
      otvalid_d = 1'b0;
    end

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (hdr_legal) begin
            otdata_d  = {MAGIC_OUT, hdr_len};
            otvalid_d = 1'b1;
            sum_d     = '0;
            cnt_d     = hdr_len;
            state_d   = (hdr_len == 16'd0) ? S_TRL : S_PAY;
          end else if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end

      S_PAY: begin
        if (accept) begin
          otdata_d  = bus.itdata;
          otvalid_d = 1'b1;
          sum_d     = sum_q + bus.itdata;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_TRL;
          end
        end
      end

      S_TRL: begin
        if (out_free) begin
          otdata_d  = sum_q;
          otvalid_d = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = S_HDR;
        end
      end

      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HDR;
      otvalid_q <= 1'b0;
      otdata_q  <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      otvalid_q <= otvalid_d;
      otdata_q  <= otdata_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.itready = itready;
  assign bus.otvalid = otvalid_q;
  assign bus.otdata  = otdata_q;
  assign busy        = (state_q != S_HDR);
  assign pkt_cnt     = pkt_cnt_q;
  assign err_cnt     = err_cnt_q;

  // A held reply word must not move until the downstream takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (otvalid_q && !bus.otready) |=> (otvalid_q && $stable(otdata_q)));

  a_no_input_in_trailer: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_TRL) |-> !itready);

endmodule

// File: tb/tb_usb_pkt_echo.sv
// Randomized scoreboard bench for usb_pkt_echo: the driver pushes expected reply words derived
// from packet-level rules, a separate monitor pops and compares on every reply handshake.
module tb_usb_pkt_echo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  usb_pkt_echo_if bus();

  usb_pkt_echo #(
    .MAGIC_IN (16'hA55A),
    .MAGIC_OUT(16'h5AA5),
    .MAX_LEN  (1024)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          pop_cyc[$];
  logic [31:0] pay[$];
  int          exp_pkt = 0;
  int          exp_err = 0;
  bit          rand_rdy = 1'b0;
  bit          gaps = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready: always 1, or a fair coin per cycle.
  initial begin
    bus.otready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.otready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every retired reply word against the scoreboard and
  // checks that a stalled word is held.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("held_valid", {31'd0, bus.otvalid}, 32'd1);
          check("held_data", bus.otdata, prev_dat);
        end
        if (bus.otvalid && bus.otready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", bus.otdata);
          end else begin
            check("otdata", bus.otdata, exp_q.pop_front());
          end
          pop_cyc.push_back(cyc);
        end
        prev_stall = bus.otvalid && !bus.otready;
        prev_dat   = bus.otdata;
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    bit acc = 1'b0;
    if (gaps) begin
      bus.itvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.itvalid = 1'b1;
    bus.itdata  = w;
    do begin
      @(negedge clk);
      acc = bus.itready;
      if (!acc) t++;
    end while (!acc && t < 1000);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL input_timeout: word %h not accepted after %0d cycles", w, t);
    end
    @(posedge clk);
    #1;
    bus.itvalid = 1'b0;
  endtask

  // Reference: a legal header yields header', payload..., sum; anything else bumps err.
  task automatic send_pkt(input logic [31:0] hdr);
    bit          legal;
    logic [31:0] s = '0;
    legal = (hdr[31:16] == 16'hA55A) && (int'(hdr[15:0]) <= 1024);
    if (legal) begin
      exp_q.push_back({16'h5AA5, hdr[15:0]});
      foreach (pay[i]) begin
        exp_q.push_back(pay[i]);
        s = s + pay[i];
      end
      exp_q.push_back(s);
      exp_pkt++;
    end else if (exp_err < 65535) begin
      exp_err++;
    end
    send_word(hdr);
    if (legal) foreach (pay[i]) send_word(pay[i]);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.otvalid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'(exp_pkt & 32'hFFFF));
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'(exp_err));
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic rand_payload(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back($urandom);
  endtask

  initial begin
    logic [31:0] hdr;
    rst_n       = 1'b0;
    bus.itvalid = 1'b0;
    bus.itdata  = '0;
    #1;
    check("rst_otvalid", {31'd0, bus.otvalid}, 32'd0);
    check("rst_otdata", bus.otdata, 32'd0);
    check("rst_itready", {31'd0, bus.itready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: three-word packet, back-to-back output
    pop_cyc.delete();
    pay = {32'd1, 32'd2, 32'd3};
    send_pkt(32'hA55A0003);
    drain();
    check("t1_words", 32'(pop_cyc.size()), 32'd5);
    if (pop_cyc.size() == 5) check("t1_span", 32'(pop_cyc[4] - pop_cyc[0]), 32'd4);
    check_counters("t1");

    // 2: empty packet gives header and a zero trailer
    pop_cyc.delete();
    pay.delete();
    send_pkt(32'hA55A0000);
    drain();
    check("t2_words", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) check("t2_span", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    check_counters("t2");

    // 3: bad magic dropped, then a one-word packet
    pay.delete();
    send_pkt(32'hDEADBEEF);
    pay = {32'h0000000A};
    send_pkt(32'hA55A0001);
    drain();
    check_counters("t3");

    // 5: length just above the limit is rejected; next packet still echoes
    pay.delete();
    send_pkt(32'hA55A0401);
    pay = {32'h12345678, 32'h9ABCDEF0};
    send_pkt(32'hA55A0002);
    drain();
    check_counters("t5");

    // 4: random downstream backpressure, wrap-around sum, long packet, random traffic
    rand_rdy = 1'b1;
    pay = {32'hFFFFFFFF, 32'hFFFFFFFF};
    send_pkt(32'hA55A0002);
    rand_payload(256);
    send_pkt(32'hA55A0100);
    rand_payload(1024);
    send_pkt(32'hA55A0400);
    gaps = 1'b1;
    for (int p = 0; p < 30; p++) begin
      case ($urandom_range(0, 4))
        0: begin
          hdr = $urandom;
          if (hdr[31:16] == 16'hA55A) hdr[31:16] = 16'h0000;
          pay.delete();
        end
        1: begin
          hdr = {16'hA55A, 16'($urandom_range(1025, 65535))};
          pay.delete();
        end
        default: begin
          hdr = {16'hA55A, 16'($urandom_range(0, 12))};
          rand_payload(int'(hdr[15:0]));
        end
      endcase
      send_pkt(hdr);
    end
    drain();
    check_counters("t4");

    // 6: reset in the middle of a packet
    rand_rdy = 1'b0;
    gaps     = 1'b0;
    exp_q.push_back(32'h5AA50005);
    exp_q.push_back(32'h00000011);
    exp_q.push_back(32'h00000022);
    send_word(32'hA55A0005);
    send_word(32'h00000011);
    send_word(32'h00000022);
    check("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    check("t6_otvalid", {31'd0, bus.otvalid}, 32'd0);
    check("t6_itready", {31'd0, bus.itready}, 32'd0);
    check_counters("t6_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pop_cyc.delete();
    pay = {32'h00000007};
    send_pkt(32'hA55A0001);
    drain();
    check("t6_words", 32'(pop_cyc.size()), 32'd3);
    check_counters("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
